// File: rtl/camera_pkg.sv
// Shared definitions for the camera display path: pixel width, the
// saturated channel value and the colour mapping mode encodings.
package camera_pkg;

    localparam int PIX_W_DEF = 12;
    localparam int FULL_DEF  = (1 << PIX_W_DEF) - 1;

    typedef enum logic [1:0] {
        MODE_REPLICATE = 2'd0,
        MODE_HEAT      = 2'd1,
        MODE_BINARY    = 2'd2,
        MODE_INVERT    = 2'd3
    } mode_t;

endpackage

// File: rtl/heatmap_lut.sv
// Heat-map false colour: maps a 2-bit segment and a full-scale ramp
// inside that segment onto blue -> cyan -> green -> yellow -> red.
module heatmap_lut #(
    parameter int PIX_W = 12,
    parameter int FULL  = 4095
) (
    input  logic [1:0]       seg,
    input  logic [PIX_W-1:0] ramp,
    output logic [PIX_W-1:0] red,
    output logic [PIX_W-1:0] green,
    output logic [PIX_W-1:0] blue
);

    localparam logic [PIX_W-1:0] FULL_V = PIX_W'(FULL);

    // Pick the channel recipe for the segment; ramp never exceeds FULL so
    // the subtractions cannot wrap.
    always_comb begin
        red   = '0;
        green = '0;
        blue  = '0;
        unique case (seg)
            2'd0: begin
                red   = '0;
                green = ramp;
                blue  = FULL_V;
            end
            2'd1: begin
                red   = '0;
                green = FULL_V;
                blue  = FULL_V - ramp;
            end
            2'd2: begin
                red   = ramp;
                green = FULL_V;
                blue  = '0;
            end
            default: begin
                red   = FULL_V;
                green = FULL_V - ramp;
                blue  = '0;
            end
        endcase
    end

endmodule

// File: rtl/grey_to_pseudocolor.sv
// Grey-to-pseudocolour stream converter. Expands a single grey channel
// into RGB using a per-frame mode (replicate, heat map, binary, invert).
// Two-cycle fixed latency, no backpressure.
// Optional build macro PSEUDOCOLOR_FRAME_STATS_EN adds per-frame pixel
// count and maximum grey outputs.
module grey_to_pseudocolor
    import camera_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int THRESH = 2000,
    parameter int FULL   = FULL_DEF
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [PIX_W-1:0] iGrey,
    input  logic             iDVAL,
    input  logic             iFVAL,
    input  logic [1:0]       iMode,
    output logic [PIX_W-1:0] oRed,
    output logic [PIX_W-1:0] oGreen,
    output logic [PIX_W-1:0] oBlue,
    output logic             oDVAL,
    output logic [1:0]       oMode
`ifdef PSEUDOCOLOR_FRAME_STATS_EN
    ,
    output logic [23:0]      oPixCount,
    output logic [PIX_W-1:0] oGreyMax
`endif
);

    localparam logic [PIX_W-1:0] FULL_V   = PIX_W'(FULL);
    localparam logic [PIX_W-1:0] THRESH_V = PIX_W'(THRESH);

    logic             fval_d;
    logic             fval_rise;
    mode_t            active_mode;
    mode_t            pix_mode;

    logic             s1_valid;
    logic [PIX_W-1:0] s1_grey;
    logic [1:0]       s1_seg;
    logic [PIX_W-1:0] s1_ramp;
    logic             s1_bin;
    mode_t            s1_mode;

    logic [PIX_W-1:0] heat_r;
    logic [PIX_W-1:0] heat_g;
    logic [PIX_W-1:0] heat_b;
    logic [PIX_W-1:0] nxt_r;
    logic [PIX_W-1:0] nxt_g;
    logic [PIX_W-1:0] nxt_b;

    // A pixel arriving on the frame-start cycle already uses the new mode.
    assign fval_rise = iFVAL & ~fval_d;
    assign pix_mode  = fval_rise ? mode_t'(iMode) : active_mode;
    assign oMode     = active_mode;

    // Frame edge detection and mode latch; mode only changes at frame start.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fval_d      <= 1'b0;
            active_mode <= MODE_REPLICATE;
        end else begin
            fval_d <= iFVAL;
            if (fval_rise) begin
                active_mode <= mode_t'(iMode);
            end
        end
    end

    // Stage 1: capture the pixel and pre-split it into segment and ramp.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1_valid <= 1'b0;
            s1_grey  <= '0;
            s1_seg   <= '0;
            s1_ramp  <= '0;
            s1_bin   <= 1'b0;
            s1_mode  <= MODE_REPLICATE;
        end else begin
            s1_valid <= iDVAL;
            if (iDVAL) begin
                s1_grey <= iGrey;
                s1_seg  <= iGrey[PIX_W-1:PIX_W-2];
                s1_ramp <= {iGrey[PIX_W-3:0], iGrey[PIX_W-3:PIX_W-4]};
                s1_bin  <= (iGrey > THRESH_V);
                s1_mode <= pix_mode;
            end
        end
    end

    heatmap_lut #(
        .PIX_W (PIX_W),
        .FULL  (FULL)
    ) u_heatmap_lut (
        .seg   (s1_seg),
        .ramp  (s1_ramp),
        .red   (heat_r),
        .green (heat_g),
        .blue  (heat_b)
    );

    // Select the colour recipe for the pixel held in stage 1.
    always_comb begin
        nxt_r = s1_grey;
        nxt_g = s1_grey;
        nxt_b = s1_grey;
        unique case (s1_mode)
            MODE_REPLICATE: begin
                nxt_r = s1_grey;
                nxt_g = s1_grey;
                nxt_b = s1_grey;
            end
            MODE_HEAT: begin
                nxt_r = heat_r;
                nxt_g = heat_g;
                nxt_b = heat_b;
            end
            MODE_BINARY: begin
                nxt_r = s1_bin ? '0 : FULL_V;
                nxt_g = s1_bin ? '0 : FULL_V;
                nxt_b = s1_bin ? '0 : FULL_V;
            end
            default: begin
                nxt_r = FULL_V - s1_grey;
                nxt_g = FULL_V - s1_grey;
                nxt_b = FULL_V - s1_grey;
            end
        endcase
    end

    // Stage 2: register the colour channels; idle cycles hold the last pixel.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDVAL  <= 1'b0;
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
        end else begin
            oDVAL <= s1_valid;
            if (s1_valid) begin
                oRed   <= nxt_r;
                oGreen <= nxt_g;
                oBlue  <= nxt_b;
            end
        end
    end

`ifdef PSEUDOCOLOR_FRAME_STATS_EN
    logic [23:0]      acc_count;
    logic [PIX_W-1:0] acc_max;
    logic             fval_fall;

    assign fval_fall = ~iFVAL & fval_d;

    // Per-frame accumulation; the frame-start pixel seeds fresh totals and
    // the published values only change when the frame ends.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            acc_count <= '0;
            acc_max   <= '0;
            oPixCount <= '0;
            oGreyMax  <= '0;
        end else begin
            if (fval_rise) begin
                acc_count <= iDVAL ? 24'd1 : 24'd0;
                acc_max   <= iDVAL ? iGrey : '0;
            end else if (iFVAL && iDVAL) begin
                if (acc_count != '1) begin
                    acc_count <= acc_count + 24'd1;
                end
                if (iGrey > acc_max) begin
                    acc_max <= iGrey;
                end
            end
            if (fval_fall) begin
                oPixCount <= acc_count;
                oGreyMax  <= acc_max;
            end
        end
    end
`endif

endmodule

// File: tb/tb_grey_to_pseudocolor.sv
// Self-checking bench for grey_to_pseudocolor: a table of single-pixel
// frames per mode, plus hand sequences for reset, latency, back-to-back
// heat map, mode latching, output hold and mid-frame reset.
module tb_grey_to_pseudocolor;

    logic        iCLK;
    logic        iRST;
    logic [11:0] iGrey;
    logic        iDVAL;
    logic        iFVAL;
    logic [1:0]  iMode;
    logic [11:0] oRed;
    logic [11:0] oGreen;
    logic [11:0] oBlue;
    logic        oDVAL;
    logic [1:0]  oMode;
`ifdef PSEUDOCOLOR_FRAME_STATS_EN
    logic [23:0] oPixCount;
    logic [11:0] oGreyMax;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] grey;
        logic [11:0] exp_r;
        logic [11:0] exp_g;
        logic [11:0] exp_b;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    grey_to_pseudocolor dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iGrey     (iGrey),
        .iDVAL     (iDVAL),
        .iFVAL     (iFVAL),
        .iMode     (iMode),
        .oRed      (oRed),
        .oGreen    (oGreen),
        .oBlue     (oBlue),
        .oDVAL     (oDVAL),
        .oMode     (oMode)
`ifdef PSEUDOCOLOR_FRAME_STATS_EN
        ,
        .oPixCount (oPixCount),
        .oGreyMax  (oGreyMax)
`endif
    );

    // Free-running pixel clock.
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [11:0] grey,
                                 input logic dval, input logic fval);
        iMode = mode;
        iGrey = grey;
        iDVAL = dval;
        iFVAL = fval;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkRgb(input string name, input int r, input int g, input int b);
        checkOutput({name, ".dval"}, int'(oDVAL), 1);
        checkOutput({name, ".r"}, int'(oRed), r);
        checkOutput({name, ".g"}, int'(oGreen), g);
        checkOutput({name, ".b"}, int'(oBlue), b);
    endtask

    // Directed stimulus and checks.
    initial begin
        int heat_in [5];
        int heat_r [5];
        int heat_g [5];
        int heat_b [5];

        checks   = 0;
        failures = 0;

        vecs[0]  = '{2'd0, 12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5};
        vecs[1]  = '{2'd0, 12'd0,    12'd0,    12'd0,    12'd0};
        vecs[2]  = '{2'd0, 12'd4095, 12'd4095, 12'd4095, 12'd4095};
        vecs[3]  = '{2'd1, 12'd512,  12'd0,    12'd2050, 12'd4095};
        vecs[4]  = '{2'd1, 12'd1500, 12'd0,    12'd4095, 12'd2190};
        vecs[5]  = '{2'd1, 12'd2600, 12'd2210, 12'd4095, 12'd0};
        vecs[6]  = '{2'd1, 12'd3500, 12'd4095, 12'd2382, 12'd0};
        vecs[7]  = '{2'd2, 12'd2000, 12'd4095, 12'd4095, 12'd4095};
        vecs[8]  = '{2'd2, 12'd2001, 12'd0,    12'd0,    12'd0};
        vecs[9]  = '{2'd2, 12'd0,    12'd4095, 12'd4095, 12'd4095};
        vecs[10] = '{2'd2, 12'd4095, 12'd0,    12'd0,    12'd0};
        vecs[11] = '{2'd3, 12'd100,  12'd3995, 12'd3995, 12'd3995};
        vecs[12] = '{2'd3, 12'd0,    12'd4095, 12'd4095, 12'd4095};
        vecs[13] = '{2'd3, 12'd4095, 12'd0,    12'd0,    12'd0};
        vecs[14] = '{2'd1, 12'd0,    12'd0,    12'd0,    12'd4095};
        vecs[15] = '{2'd1, 12'd4095, 12'd4095, 12'd0,    12'd0};

        heat_in = '{0, 1024, 2048, 3072, 4095};
        heat_r  = '{0, 0, 0, 4095, 4095};
        heat_g  = '{0, 4095, 4095, 4095, 0};
        heat_b  = '{4095, 4095, 0, 0, 0};

        // Reset held for 3 cycles with a valid pixel on the input.
        iRST = 1'b1;
        applyStimulus(2'd0, 12'd1234, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("reset.dval", int'(oDVAL), 0);
            checkOutput("reset.rgb", int'({oRed, oGreen, oBlue}), 0);
            checkOutput("reset.mode", int'(oMode), 0);
        end

        // First post-reset pixel must emerge exactly 2 edges later.
        iRST = 1'b0;
        step();
        applyStimulus(2'd0, 12'd1234, 1'b0, 1'b1);
        checkOutput("latency.edge1.dval", int'(oDVAL), 0);
        step();
        checkRgb("latency.edge2", 1234, 1234, 1234);
        step();
        checkOutput("latency.edge3.dval", int'(oDVAL), 0);
        checkOutput("hold.r", int'(oRed), 1234);

        // Table: each vector is a one-pixel frame, pixel on the frame-start cycle.
        for (int v = 0; v < NV; v++) begin
            applyStimulus(2'd0, 12'd0, 1'b0, 1'b0);
            step();
            applyStimulus(vecs[v].mode, vecs[v].grey, 1'b1, 1'b1);
            step();
            applyStimulus(2'd0, 12'd0, 1'b0, 1'b1);
            step();
            checkRgb($sformatf("vec%0d", v), int'(vecs[v].exp_r),
                     int'(vecs[v].exp_g), int'(vecs[v].exp_b));
            checkOutput($sformatf("vec%0d.mode", v), int'(oMode), int'(vecs[v].mode));
        end

        // Back-to-back heat-map burst, one result per clock.
        applyStimulus(2'd0, 12'd0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 7; i++) begin
            if (i < 5) applyStimulus(2'd1, 12'(heat_in[i]), 1'b1, 1'b1);
            else       applyStimulus(2'd1, 12'd0, 1'b0, 1'b1);
            step();
            if (i >= 1 && i <= 5) begin
                checkRgb($sformatf("heat%0d", i - 1), heat_r[i-1], heat_g[i-1], heat_b[i-1]);
            end
        end
        checkOutput("heat.tail.dval", int'(oDVAL), 0);

        // Mode change mid-frame is ignored until the next frame start.
        applyStimulus(2'd0, 12'd0, 1'b0, 1'b0);
        step();
        applyStimulus(2'd0, 12'd0, 1'b0, 1'b1);
        step();
        applyStimulus(2'd3, 12'd100, 1'b1, 1'b1);
        step();
        applyStimulus(2'd3, 12'd0, 1'b0, 1'b1);
        step();
        checkRgb("latch.midframe", 100, 100, 100);
        checkOutput("latch.midframe.mode", int'(oMode), 0);
        applyStimulus(2'd3, 12'd0, 1'b0, 1'b0);
        step();
        applyStimulus(2'd3, 12'd100, 1'b1, 1'b1);
        step();
        applyStimulus(2'd0, 12'd0, 1'b0, 1'b1);
        step();
        checkRgb("latch.newframe", 3995, 3995, 3995);
        checkOutput("latch.newframe.mode", int'(oMode), 3);

        // A pixel with iFVAL low still converts using the active mode.
        applyStimulus(2'd1, 12'd200, 1'b1, 1'b0);
        step();
        applyStimulus(2'd1, 12'd0, 1'b0, 1'b0);
        step();
        checkRgb("novfal", 3895, 3895, 3895);
        checkOutput("novfal.mode", int'(oMode), 3);

        // Mid-frame reset flushes the pipe; fval still high relatches the mode.
        applyStimulus(2'd3, 12'd0, 1'b0, 1'b0);
        step();
        applyStimulus(2'd3, 12'd7, 1'b1, 1'b1);
        step();
        iRST = 1'b1;
        applyStimulus(2'd2, 12'd0, 1'b0, 1'b1);
        step();
        checkOutput("midreset.dval", int'(oDVAL), 0);
        checkOutput("midreset.r", int'(oRed), 0);
        checkOutput("midreset.mode", int'(oMode), 0);
        iRST = 1'b0;
        step();
        checkOutput("midreset.dval2", int'(oDVAL), 0);
        checkOutput("midreset.relatch", int'(oMode), 2);

`ifdef PSEUDOCOLOR_FRAME_STATS_EN
        // Frame of 640 pixels peaking at 3000, then a short frame peaking at 50.
        applyStimulus(2'd0, 12'd0, 1'b0, 1'b0);
        step();
        checkOutput("stats.reset.count", int'(oPixCount), 0);
        for (int i = 0; i < 640; i++) begin
            applyStimulus(2'd0, (i == 321) ? 12'd3000 : 12'(i % 2000), 1'b1, 1'b1);
            step();
            applyStimulus(2'd0, 12'd0, 1'b0, 1'b1);
            if (i % 3 == 0) step();
        end
        applyStimulus(2'd0, 12'd0, 1'b0, 1'b0);
        step();
        checkOutput("stats.f1.count", int'(oPixCount), 640);
        checkOutput("stats.f1.max", int'(oGreyMax), 3000);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'd0, 12'(i * 5 + 5), 1'b1, 1'b1);
            step();
            checkOutput("stats.hold.count", int'(oPixCount), 640);
            checkOutput("stats.hold.max", int'(oGreyMax), 3000);
        end
        applyStimulus(2'd0, 12'd0, 1'b0, 1'b0);
        step();
        checkOutput("stats.f2.count", int'(oPixCount), 10);
        checkOutput("stats.f2.max", int'(oGreyMax), 50);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grey_to_pseudocolor.md
Name: grey_to_pseudocolor

Overview:
Stream converter for the camera display path. It takes a single-channel 12-bit grey pixel stream and expands it back to three 12-bit colour channels for the VGA/SDRAM writer. The colour mapping is selectable: grey replicate, heat-map false colour, binary, or inverted. This block is the inverse-direction companion of the RGB-to-grey stage and sits directly downstream of it.

Parameters:
- PIX_W, 12, bit width of the grey input and of each colour output channel.
- THRESH, 2000, binary-mode threshold compared against the grey value.
- FULL, 4095, saturated channel value; must equal 2^PIX_W-1.

Ports:
- iCLK  input  1  pixel clock.
- iRST  input  1  synchronous, active-high reset.
- iGrey  input  PIX_W  grey pixel; qualified by iDVAL.
- iDVAL  input  1  input pixel valid.
- iFVAL  input  1  frame valid; high for the whole frame.
- iMode  input  2  requested mode: 0 replicate, 1 heat map, 2 binary, 3 inverted.
- oRed  output  PIX_W  red channel.
- oGreen  output  PIX_W  green channel.
- oBlue  output  PIX_W  blue channel.
- oDVAL  output  1  output pixel valid.
- oMode  output  2  mode currently applied.

Behaviour:
- Reset (iRST=1 at a clock edge): oRed, oGreen, oBlue = 0; oDVAL = 0; oMode = 0; all pipeline valids cleared; fval_d = 0. Reset overrides every other input in the same cycle.
- Mode latch: fval_d registers iFVAL each cycle. On a rising edge of iFVAL (iFVAL=1, fval_d=0), the active mode register loads iMode. Changes to iMode at any other time are ignored, so no mode tearing occurs mid-frame.
  - oMode shows the active mode register.
  - The pixel arriving in the same cycle as the rising edge already uses the new mode.
- Pipeline: fixed 2-cycle latency; oDVAL is iDVAL delayed by 2 cycles. There is no backpressure. Pixels with iDVAL=0 are not converted, and the outputs hold their last values.
  - Stage 1 registers:
    - the grey value;
    - seg = g[11:10];
    - ramp = {g[9:0], g[9:8]} (12-bit ramp, 0..4095);
    - a binary flag = (g > THRESH);
    - the valid bit;
    - the mode for that pixel.
  - Stage 2 registers the three output channels and oDVAL.
- Mode 0 (replicate): R = G = B = g.
- Mode 1 (heat map), by seg:
  - 0: R=0, G=ramp, B=FULL.
  - 1: R=0, G=FULL, B=FULL-ramp.
  - 2: R=ramp, G=FULL, B=0.
  - 3: R=FULL, G=FULL-ramp, B=0.
  - Boundaries: g=0 gives (0,0,FULL); g=4095 gives (FULL,0,0).
- Mode 2 (binary): if g > THRESH, all channels = 0; otherwise all channels = FULL. g=THRESH exactly maps to FULL (white).
- Mode 3 (inverted): each channel = FULL - g.
- Arithmetic: all subtractions are unsigned PIX_W-bit and never underflow, since the operands are ≤ FULL. Outputs are never wider than PIX_W.
- Mid-frame reset: the pipeline flushes and mode returns to 0. After reset deasserts, if iFVAL is already high, fval_d=0 means the next cycle sees a rising edge and latches iMode.
- iDVAL while iFVAL=0: the pixel is still converted using the current active mode.

Optional Feature:
- Macro: PSEUDOCOLOR_FRAME_STATS_EN.
- When defined, the block adds two outputs:
  - oPixCount (24 bits): number of iDVAL pixels in the last completed frame.
  - oGreyMax (PIX_W bits): maximum grey value in the last completed frame.
- Internal behaviour when defined:
  - Counter and max accumulators clear on the iFVAL rising edge.
  - They accumulate while iFVAL=1 and iDVAL=1.
  - On the iFVAL falling edge, both values are copied to the outputs.
  - The counter saturates at 2^24-1.
  - Reset clears everything to 0.
- When undefined, the outputs and logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package camera_pkg holds:
  - the PIX_W default;
  - mode constants MODE_REPLICATE=0, MODE_HEAT=1, MODE_BINARY=2, MODE_INVERT=3;
  - the FULL constant.
- One natural sub-module, heatmap_lut, is combinational: (seg, ramp) -> (R, G, B). It is instantiated in stage 2.

Test Plan:
- Reset: hold iRST=1 for 3 cycles with iDVAL=1, iGrey=1234 -> all outputs 0 and oDVAL=0 throughout; first valid output appears exactly 2 cycles after the first post-reset iDVAL.
- Replicate: mode 0, iGrey=0x5A5 -> two cycles later oRed=oGreen=oBlue=0x5A5 with oDVAL=1.
- Heat map: mode 1, feed g=0, 1024, 2048, 3072, 4095 back-to-back. Required outputs, 2-cycle latency, one per clock:
  - (0, 0, 4095)
  - (0, 4095, 4095)
  - (0, 4095, 0)
  - (4095, 4095, 0)
  - (4095, 0, 0)
- Binary boundary: mode 2, g=2000 -> all channels 4095; g=2001 -> all channels 0.
- Mode latch: with iFVAL high and iMode=0, change iMode to 3 mid-frame -> outputs stay replicate. Drop iFVAL then raise it again with iMode=3 -> g=100 yields 3995 on all channels and oMode=3.
- Stats (with macro defined): frame of 640 valid pixels with maximum grey 3000 -> after iFVAL falls, oPixCount=640 and oGreyMax=3000; values hold unchanged through the next frame until its end.
